// File: rtl/alsu_cmd_issuer_pkg.sv
// alsu_cmd_issuer_pkg: command layout, opcode names and ALSU timing shared by the issue stage
package alsu_cmd_issuer_pkg;
    typedef enum logic [2:0] {
        OR        = 3'd0,
        XOR       = 3'd1,
        ADD       = 3'd2,
        MULT      = 3'd3,
        SHIFT     = 3'd4,
        ROTATE    = 3'd5,
        INVALID_6 = 3'd6,
        INVALID_7 = 3'd7
    } opcode_e;
    typedef struct packed {
        opcode_e           opcode;
        logic signed [2:0] a;
        logic signed [2:0] b;
        logic              cin;
        logic              serial_in;
        logic              red_op_a;
        logic              red_op_b;
        logic              bypass_a;
        logic              bypass_b;
        logic              direction;
    } alsu_cmd_t;
    localparam int ALSU_LAT_C = 2;
endpackage

// File: rtl/alsu_cmd_fifo.sv
// alsu_cmd_fifo: synchronous command FIFO with flush, occupancy count and full/empty flags
module alsu_cmd_fifo
    import alsu_cmd_issuer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  alsu_cmd_t                din,
    output alsu_cmd_t                dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    alsu_cmd_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            wr;
    logic            rd;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr    = push && !full && !rst && !flush;
    assign rd    = pop && !empty && !rst && !flush;
    assign dout  = mem[rd_ptr];
    // storage is not reset; only entries below the count are ever read
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/alsu_cmd_issuer.sv
// alsu_cmd_issuer: buffers ALSU commands, drives ALSU pins one per cycle and tags results
module alsu_cmd_issuer
    import alsu_cmd_issuer_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int ALSU_LATENCY = ALSU_LAT_C
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  alsu_cmd_t              cmd_data,
    input  logic                   issue_en,
    output logic [2:0]             opcode,
    output logic signed [2:0]      A,
    output logic signed [2:0]      B,
    output logic                   cin,
    output logic                   serial_in,
    output logic                   red_op_A,
    output logic                   red_op_B,
    output logic                   bypass_A,
    output logic                   bypass_B,
    output logic                   direction,
    output logic                   issue_valid,
    output logic                   result_valid,
    output logic [$clog2(DEPTH):0] count
);
    alsu_cmd_t               head;
    alsu_cmd_t               cmd_q;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [ALSU_LATENCY-1:0] tag;
    assign cmd_ready    = !rst && !flush && !full;
    assign push         = cmd_valid && cmd_ready;
    assign pop          = issue_en && !empty && !flush && !rst;
    assign result_valid = tag[ALSU_LATENCY-1];
    assign opcode       = cmd_q.opcode;
    assign A            = cmd_q.a;
    assign B            = cmd_q.b;
    assign cin          = cmd_q.cin;
    assign serial_in    = cmd_q.serial_in;
    assign red_op_A     = cmd_q.red_op_a;
    assign red_op_B     = cmd_q.red_op_b;
    assign bypass_A     = cmd_q.bypass_a;
    assign bypass_B     = cmd_q.bypass_b;
    assign direction    = cmd_q.direction;
    alsu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (cmd_data),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    // ALSU pins only change on an issue so the ALSU sees stable inputs otherwise; flush keeps them
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= '0;
            issue_valid <= 1'b0;
            tag         <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
            tag         <= '0;
        end else begin
            if (pop) cmd_q <= head;
            issue_valid <= pop;
            tag         <= (tag << 1) | ALSU_LATENCY'(issue_valid);
        end
    end
endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// tb_alsu_cmd_issuer: directed stimulus with a scoreboard monitor for issue order and result tags
module tb_alsu_cmd_issuer;
    import alsu_cmd_issuer_pkg::*;
    logic        clk = 0;
    logic        rst, flush, cmd_valid, cmd_ready, issue_en;
    logic [15:0] cmd_data;
    logic [2:0]  opcode;
    logic signed [2:0] A, B;
    logic        cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
    logic        issue_valid, result_valid;
    logic [2:0]  count;
    logic [15:0] pins;
    logic [15:0] sb[$];
    int          tq[$];
    int          cyc = 0;
    logic        clr = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    alsu_cmd_issuer dut (
        .clk(clk), .rst(rst), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .issue_en(issue_en), .opcode(opcode), .A(A), .B(B), .cin(cin),
        .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
        .bypass_B(bypass_B), .direction(direction), .issue_valid(issue_valid),
        .result_valid(result_valid), .count(count)
    );

    assign pins = {opcode, A, B, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        bit acc = 0;
        cmd_valid = 1;
        cmd_data  = d;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            step();
        end
        if (acc) sb.push_back(d);
        else chk("send_timeout", 0, 1);
    endtask

    always @(posedge clk) begin
        cyc++;
        clr = rst || flush;
    end

    always @(negedge clk) begin
        bit due;
        if (clr) tq.delete();
        due = tq.size() > 0 && tq[0] == cyc;
        chk("result_valid", {31'd0, result_valid}, {31'd0, due});
        if (due) void'(tq.pop_front());
        if (issue_valid === 1'b1) begin
            tq.push_back(cyc + ALSU_LAT_C);
            if (sb.size() == 0) chk("issue_unexpected", 1, 0);
            else chk("issue_cmd", {16'd0, pins}, {16'd0, sb.pop_front()});
        end
    end

    initial begin
        rst = 1; flush = 0; cmd_valid = 1; cmd_data = 16'hFFFF; issue_en = 1;
        step(); step();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_pins", pins, 0);
        chk("rst_issue", issue_valid, 0);
        chk("rst_result", result_valid, 0);
        rst = 0; cmd_valid = 0;
        #1 chk("rel_ready", cmd_ready, 1);

        send(16'h4E80);
        cmd_valid = 0;
        step();
        chk("add_opcode", opcode, 2);
        chk("add_A", {29'd0, A}, 3);
        chk("add_B", {29'd0, B}, 5);
        chk("add_issue", issue_valid, 1);
        chk("add_count", count, 0);
        step();
        chk("add_issue_once", issue_valid, 0);
        chk("add_result_early", result_valid, 0);
        step();
        chk("add_result", result_valid, 1);
        step();
        chk("add_result_once", result_valid, 0);

        issue_en = 0;
        send(16'h0001); send(16'h2C42); send(16'hD5AA); send(16'hFFFF);
        cmd_data = 16'h1234;
        chk("fill_count", count, 4);
        chk("fill_ready", cmd_ready, 0);
        step();
        chk("fill_hold_count", count, 4);
        chk("fill_hold_ready", cmd_ready, 0);
        cmd_valid = 0; issue_en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_count", count, 3 - i);
            chk("drain_issue", issue_valid, 1);
            chk("drain_ready", cmd_ready, 1);
        end
        step();
        chk("drain_idle", issue_valid, 0);

        issue_en = 0;
        send(16'h8123); send(16'hA456);
        chk("sim_count_pre", count, 2);
        issue_en = 1;
        send(16'h3789);
        chk("sim_count", count, 2);
        cmd_valid = 0;
        step(); chk("sim_count1", count, 1);
        step(); chk("sim_count0", count, 0);
        step(); step(); step();

        issue_en = 0;
        send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
        issue_en = 1;
        send(16'h5555);
        chk("fl_count_pre", count, 3);
        issue_en = 0; flush = 1; cmd_data = 16'h6666;
        #1 chk("fl_ready", cmd_ready, 0);
        step();
        flush = 0; cmd_valid = 0; sb.delete();
        chk("fl_count", count, 0);
        chk("fl_issue", issue_valid, 0);
        chk("fl_pins_hold", pins, 16'h2222);
        step();
        chk("fl_result0", result_valid, 0);
        chk("fl_count_after", count, 0);
        step();
        chk("fl_result1", result_valid, 0);
        chk("fl_pins_hold2", pins, 16'h2222);

        issue_en = 1;
        send(16'hB0F3); send(16'h5A5A);
        rst = 1; cmd_data = 16'h7777;
        step();
        chk("mrst_pins", pins, 0);
        chk("mrst_count", count, 0);
        chk("mrst_issue", issue_valid, 0);
        chk("mrst_ready", cmd_ready, 0);
        step();
        rst = 0; cmd_valid = 0; sb.delete();
        #1 chk("mrst_release_ready", cmd_ready, 1);
        chk("mrst_result", result_valid, 0);

        send(16'h6A55);
        cmd_valid = 0;
        for (int i = 0; i < 20 && (sb.size() != 0 || tq.size() != 0); i++) step();
        chk("final_sb_empty", sb.size(), 0);
        chk("final_tags_empty", tq.size(), 0);
        chk("final_pins", pins, 16'h6A55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alsu_cmd_issuer.md
# alsu_cmd_issuer

Upstream command stage for the ALSU. It accepts packed 16-bit ALSU commands over a valid/ready handshake and buffers them in a small FIFO. It issues at most one command per cycle onto the ALSU input pins, and generates a `result_valid` tag aligned to the ALSU's registered `out`/`leds`. Downstream logic can therefore sample ALSU results only on cycles that carry a real command.

## Interface
- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.
- `ALSU_LATENCY`, default 2: cycles from ALSU input change to registered `out`/`leds`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous queue/tag clear.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_data` in 16: command, type `alsu_cmd_t`.
- `issue_en` in 1: downstream permits issue this cycle.
- `opcode` out 3, `A` out 3 (signed), `B` out 3 (signed): driven to the ALSU.
- `cin`, `serial_in`, `red_op_A`, `red_op_B`, `bypass_A`, `bypass_B`, `direction` out 1 each: driven to the ALSU.
- `issue_valid` out 1: the ALSU pins carry a newly issued command this cycle.
- `result_valid` out 1: `issue_valid` delayed by `ALSU_LATENCY`.
- `count` out `$clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- **Command packing:**
  - [15:13] opcode, [12:10] A, [9:7] B.
  - [6] cin, [5] serial_in, [4] red_op_A, [3] red_op_B, [2] bypass_A, [1] bypass_B, [0] direction.
- **Ready:** `cmd_ready = !rst && !flush && (count < DEPTH)`. There is no pass-through when full; a pop in the same cycle does not free a slot for a push.
- **Push:** `cmd_valid && cmd_ready` writes at the tail pointer.
- **Pop:** `issue_en && count != 0 && !flush && !rst` reads the head entry into the output registers and sets `issue_valid=1` for that cycle.
- **Hold:** with no pop, `issue_valid=0` and all ALSU drive registers hold their last values, so ALSU inputs stay stable.
- **Occupancy update:** push only → +1; pop only → −1; both → unchanged.
- **Pointers:** wrap modulo `DEPTH`.
- **Flush:** count and pointers go to 0, the `result_valid` shift register clears, and `issue_valid=0`. Flush overrides push and pop in the same cycle; the offered command is dropped. ALSU drive registers keep their values.
- **Reset:** identical to flush, and additionally sets every ALSU drive output to 0. Reset has priority over flush.
- **Reset values:** all drive outputs 0; `issue_valid` 0, `result_valid` 0, `count` 0; `cmd_ready` 0 while `rst` is high.
- **Opcode passing:** opcodes 6 and 7 (invalid) are passed through unmodified; the ALSU flags them on `leds`.

## Timing
- Command accepted at edge k into an empty FIFO with `issue_en=1`:
  - `issue_valid` is high after edge k+1.
  - `result_valid` is high after edge k+1+`ALSU_LATENCY`.
- Sustained throughput is one command per cycle when `cmd_valid` and `issue_en` are held high.
- `issue_valid` is never high for two cycles on the same entry.
- `result_valid` pulses one-for-one with `issue_valid`, in order, with none dropped except by flush or reset.
- `count` is registered; `cmd_ready` is combinational from `count`, `rst` and `flush`.
- A flush or reset asserted mid-stream affects issue and tags on the following edge.

## Structure
- `ALU_pkg` gains:
  - `alsu_cmd_t`, a packed struct in the bit order above.
  - `opcode_e` enum: OR=0, XOR=1, ADD=2, MULT=3, SHIFT=4, ROTATE=5, INVALID_6=6, INVALID_7=7.
  - `ALSU_LAT_C=2`.
- Natural sub-module: `alsu_cmd_fifo`, a parameterised sync FIFO with push/pop/flush/count and full/empty flags. The issue registers and the tag shift register live in the top.

## Test plan
- **Reset:** hold `rst=1` for 2 cycles with `cmd_valid=1` → `cmd_ready=0`, `count=0`, all outputs 0. After release, `cmd_ready=1`.
- **Single ADD:** push `cmd_data=16'h4E80` (opcode=2, A=3, B=−3), `issue_en=1` → one cycle later `opcode=2`, `A=3`, `B=−3`, `issue_valid=1` for exactly one cycle. Two cycles after that, `result_valid=1` and ALSU `out=0`.
- **Fill:** `issue_en=0`, offer 5 commands back-to-back → 4 accepted, `count=4`, `cmd_ready=0`, and the 5th is held upstream. Then `issue_en=1` → 4 consecutive `issue_valid` pulses in push order, `count` 3,2,1,0, and `cmd_ready` returns after the first pop.
- **Simultaneous:** at `count=2`, push and pop in the same cycle → `count` stays 2 and order is preserved.
- **Flush:** with `count=3` and 2 tags in flight, pulse `flush` together with `cmd_valid=1` → `count=0`, the offered command is dropped, and `result_valid` stays 0 for the next 2 cycles. ALSU pins hold their last values.
- **Mid-stream reset:** assert `rst` while streaming → same as flush, plus all ALSU drive outputs become 0.
